// File: rtl/stream_packer_pkg.sv
// Shared constants and helpers for the narrow-to-wide stream packer.
package stream_packer_pkg;

    localparam int unsigned MIN_RATIO = 2;
    localparam int unsigned MAX_RATIO = 64;

    // Fill count to slot mask, (1<<n)-1 saturating at all ones for the given ratio.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned n, input int unsigned ratio);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            m[i] = (i < n) && (i < ratio);
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_packer.sv
// Width up-converter: packs RATIO narrow words into one wide word with a per-slot keep mask.
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4,
    localparam int unsigned LB_RATIO  = $clog2(RATIO)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    input  logic                        clear,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LB_RATIO:0]           fill
);

    localparam int unsigned   FW        = LB_RATIO + 1;
    localparam int unsigned   OW        = DATA_WIDTH * RATIO;
    localparam logic [FW-1:0] FILL_FULL = FW'(RATIO);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);

    if (RATIO < MIN_RATIO || RATIO > MAX_RATIO) begin : g_ratio_chk
        $error("stream_packer: RATIO outside supported range");
    end

    logic [RATIO-1:0][DATA_WIDTH-1:0] acc_r, acc_nxt;
    logic [FW-1:0]                    fill_r, fill_nxt;
    logic [OW-1:0]                    out_data_r, out_data_nxt;
    logic [RATIO-1:0]                 out_keep_r, out_keep_nxt;
    logic                             out_valid_r, out_valid_nxt;
    logic                             flush_pend_r, flush_pend_nxt;

    logic                             slot_free;
    logic                             out_exec;
    logic                             in_exec;
    logic                             xfer;
    logic [FW-1:0]                    wr_idx;
    logic [RATIO-1:0]                 keep_c;

    // Ready depends on registered state only, never on out_ready.
    assign in_ready  = !flush_pend_r &&
                       ((fill_r < FILL_FULL) || (fill_r == FILL_FULL && !out_valid_r));
    assign slot_free = !out_valid_r || out_ready;
    assign out_exec  = out_valid_r && out_ready;
    assign in_exec   = in_valid && in_ready;
    assign xfer      = slot_free &&
                       ((fill_r == FILL_FULL) || (flush_pend_r && fill_r != '0));
    assign wr_idx    = xfer ? '0 : fill_r;
    assign keep_c    = RATIO'(keep_mask(32'(fill_r), RATIO));

    // Next-state logic; clear overrides every other event.
    always_comb begin
        acc_nxt        = acc_r;
        fill_nxt       = fill_r;
        out_data_nxt   = out_data_r;
        out_keep_nxt   = out_keep_r;
        out_valid_nxt  = out_valid_r;
        flush_pend_nxt = flush_pend_r;

        if (clear) begin
            acc_nxt        = '0;
            fill_nxt       = '0;
            out_data_nxt   = '0;
            out_keep_nxt   = '0;
            out_valid_nxt  = 1'b0;
            flush_pend_nxt = 1'b0;
        end else begin
            if (xfer) begin
                out_valid_nxt = 1'b1;
                out_keep_nxt  = keep_c;
                for (int unsigned i = 0; i < RATIO; i++) begin
                    out_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = keep_c[i] ? acc_r[i] : '0;
                end
                fill_nxt = in_exec ? FILL_ONE : '0;
            end else begin
                if (out_exec) begin
                    out_valid_nxt = 1'b0;
                end
                if (in_exec) begin
                    fill_nxt = fill_r + FILL_ONE;
                end
            end

            if (in_exec) begin
                for (int unsigned i = 0; i < RATIO; i++) begin
                    if (wr_idx == FW'(i)) begin
                        acc_nxt[i] = in_data;
                    end
                end
            end

            // An empty accumulator retires a pending flush without emitting anything.
            if (flush_pend_r) begin
                if (xfer || fill_r == '0) begin
                    flush_pend_nxt = 1'b0;
                end
            end else if (flush) begin
                flush_pend_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r        <= '0;
            fill_r       <= '0;
            out_data_r   <= '0;
            out_keep_r   <= '0;
            out_valid_r  <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            acc_r        <= acc_nxt;
            fill_r       <= fill_nxt;
            out_data_r   <= out_data_nxt;
            out_keep_r   <= out_keep_nxt;
            out_valid_r  <= out_valid_nxt;
            flush_pend_r <= flush_pend_nxt;
        end
    end

    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_valid = out_valid_r;
    assign fill      = fill_r;

endmodule
